pad_bank_filtered: RTL
======================

// Module: pad_bank_filtered
// PURPOSE
//  Parametrised FPGA pad bank: NUM_PADS bidirectional IOBUF channels with per-channel pull
//  (up/down/none), registered output drive, input synchroniser, digital glitch filter and
//  edge-event pulses. Sits between the SoC pad-mux and the FPGA top-level inout pins.
//  Replaces the fixed single-pad pull wrappers. Adds open-drain mode and runtime filter depth.
// PARAMETERS
//  NUM_PADS     8             number of pad channels
//  SYNC_STAGES  2             input synchroniser flops, >=2
//  FILT_CNT_W   8             width of filter counter and threshold
//  PULL_MODE    all PULL_NONE pull_e array [NUM_PADS], per-channel pull attribute (elaboration-time)
// PORTS
//  clk_i        in     1            clock
//  rst_i        in     1            synchronous reset, active-high
//  oen_i        in     NUM_PADS     output disable per pad, 1=tri-state (push-pull mode only)
//  out_i        in     NUM_PADS     value to drive
//  od_en_i      in     NUM_PADS     1=open-drain mode for that pad
//  filt_thr_i   in     FILT_CNT_W   glitch-filter threshold, 0=bypass
//  in_o         out    NUM_PADS     synchronised, filtered pad value
//  rise_o       out    NUM_PADS     1-cycle pulse on filtered 0->1
//  fall_o       out    NUM_PADS     1-cycle pulse on filtered 1->0
//  pad_io       inout  NUM_PADS     FPGA pins
// BEHAVIOUR
//  Reset (rst_i=1 at clk_i edge): T flops=1 (all pads tri-stated), I flops=0, counters=0,
//   rise_o/fall_o=0; sync flops and in_o = RST_VAL(k): 1 for PULL_UP, else 0.
//  Output path: one-cycle registered. Next cycle T/I per pad:
//   od_en_i=0: T<=oen_i, I<=out_i.  od_en_i=1: I<=0, T<=out_i (drive low or release); oen_i ignored.
//  Pull: PULL_UP -> IOBUF with PULLUP attribute; PULL_DOWN -> PULLDOWN; PULL_NONE -> none.
//  Input: IOBUF O through SYNC_STAGES flops; s = last stage. Filter state filt (=in_o), cnt:
//   s==filt: cnt<=0.
//   s!=filt and cnt>=filt_thr_i: filt<=s, cnt<=0, rise_o/fall_o pulse next cycle with filt.
//   s!=filt otherwise: cnt<=cnt+1.
//  Latency: stable pad change reaches in_o SYNC_STAGES+filt_thr_i+1 cycles after first
//   sampling edge. Mismatch runs of <=filt_thr_i cycles are rejected, no pulse.
//  filt_thr_i change mid-count: >= compare; lowering below cnt commits on next mismatch cycle.
//  cnt never exceeds 2^FILT_CNT_W-1: it clears at threshold, and the threshold is <= the max.
//  rise_o and fall_o never assert together for one channel. Pulses are exactly one cycle.
//  Reset mid-count or mid-drive: all state returns to reset values in the same edge. No
//   pulse is generated by the reset itself.
//  Channels are fully independent. Pad loopback (own drive seen on in_o) is allowed, not suppressed.
// STRUCTURE
//  Package pad_bank_pkg: typedef enum logic [1:0] pull_e {PULL_NONE, PULL_UP, PULL_DOWN};
//   function rst_val(pull_e) returns logic.
//  Sub-module pad_filter_channel (one per pad, generate loop) contains:
//   output T/I flops, IOBUF (pull-attribute generate branch), sync chain, filter counter,
//   edge pulses.
//  Top level holds only the generate loop and parameter fan-out.
// TESTING
//  1 Reset, PULL_MODE[0]=PULL_UP, [1]=PULL_DOWN -> in_o[0]=1, in_o[1]=0, all pads Z,
//    rise/fall=0.
//  2 thr=3, pad 0->1 held 3 cycles then back to 0 -> in_o stays 0, no rise_o.
//  3 thr=3, pad 0->1 held -> in_o=1 exactly SYNC_STAGES+4 cycles after edge; rise_o high
//    one cycle.
//  4 thr=0, pad toggles every 4 cycles -> in_o follows at SYNC_STAGES+1 latency, alternating
//    rise/fall pulses.
//  5 od_en=1, out_i=0 then 1 with oen_i=0 -> pad 0 next cycle, then Z (pull-up reads 1).
//    od_en=0 -> pad = out_i.
//  6 thr=10, pad held high 5 cycles, rst_i pulsed -> cnt=0, in_o=RST_VAL, pads Z.
//    No pulse; filtering restarts from 0.

Source files
------------

// File: rtl/pad_bank_pkg.sv
// Shared types for the filtered pad bank: per-channel pull attribute and its reset value.
// Purely declarative; no logic, no latency, no backpressure.
package pad_bank_pkg;

  typedef enum logic [1:0] {
    PULL_NONE = 2'd0,
    PULL_UP   = 2'd1,
    PULL_DOWN = 2'd2
  } pull_e;

  // A pulled-up pad idles high, so its input path resets to 1 to avoid a false edge.
  function automatic logic rst_val(input pull_e p);
    return (p == PULL_UP);
  endfunction

endpackage

// File: rtl/pad_filter_channel.sv
// One pad channel: registered tri-state drive, pull, input synchroniser, glitch filter, edge pulses.
// Drive lands 1 cycle after inputs; input reaches in_o SYNC_STAGES+thr+1 edges after sampling; no backpressure.
module pad_filter_channel
  import pad_bank_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter int    FILT_CNT_W  = 8,
  parameter pull_e PULL        = PULL_NONE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  oen_i,
  input  logic                  out_i,
  input  logic                  od_en_i,
  input  logic [FILT_CNT_W-1:0] filt_thr_i,
  output logic                  in_o,
  output logic                  rise_o,
  output logic                  fall_o,
  inout  wire                   pad_io
);

  localparam logic RST_VAL = rst_val(PULL);

  logic                   r_t;
  logic                   r_i;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [FILT_CNT_W-1:0]  r_cnt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_pad_in;
  logic                   w_s;

  // Open-drain only ever drives low; out_i then selects drive-low versus release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_t <= 1'b1;
      r_i <= 1'b0;
    end else if (od_en_i) begin
      r_t <= out_i;
      r_i <= 1'b0;
    end else begin
      r_t <= oen_i;
      r_i <= out_i;
    end
  end

  assign pad_io   = r_t ? 1'bz : r_i;
  assign w_pad_in = pad_io;

  if (PULL == PULL_UP) begin : g_pullup
    pullup (pad_io);
  end else if (PULL == PULL_DOWN) begin : g_pulldown
    pulldown (pad_io);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Commit needs thr+1 consecutive mismatching samples; any agreeing sample restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_filt <= RST_VAL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= filt_thr_i) begin
        r_filt <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_o   = r_filt;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/pad_bank_filtered.sv
// Bank of NUM_PADS independent filtered bidirectional pad channels between pad-mux and FPGA pins.
// Per-channel latency as in pad_filter_channel; no backpressure.
module pad_bank_filtered
  import pad_bank_pkg::*;
#(
  parameter int    NUM_PADS    = 8,
  parameter int    SYNC_STAGES = 2,
  parameter int    FILT_CNT_W  = 8,
  parameter pull_e PULL_MODE [NUM_PADS] = '{default: PULL_NONE}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_PADS-1:0]   oen_i,
  input  logic [NUM_PADS-1:0]   out_i,
  input  logic [NUM_PADS-1:0]   od_en_i,
  input  logic [FILT_CNT_W-1:0] filt_thr_i,
  output logic [NUM_PADS-1:0]   in_o,
  output logic [NUM_PADS-1:0]   rise_o,
  output logic [NUM_PADS-1:0]   fall_o,
  inout  wire  [NUM_PADS-1:0]   pad_io
);

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_ch
    pad_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT_W  (FILT_CNT_W),
      .PULL        (PULL_MODE[g])
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .oen_i      (oen_i[g]),
      .out_i      (out_i[g]),
      .od_en_i    (od_en_i[g]),
      .filt_thr_i (filt_thr_i),
      .in_o       (in_o[g]),
      .rise_o     (rise_o[g]),
      .fall_o     (fall_o[g]),
      .pad_io     (pad_io[g])
    );
  end

endmodule
